// File: rtl/alu_pkg.sv
// alu_pkg: operation group and sub-op encodings shared by the ALU blocks
package alu_pkg;
  localparam logic [1:0] ALU_ARITH = 2'b00;
  localparam logic [1:0] ALU_LOGIC = 2'b01;
  localparam logic [1:0] ALU_SHR   = 2'b10;
  localparam logic [1:0] ALU_SHL   = 2'b11;
  localparam logic [1:0] ARITH_TFR = 2'b00;
  localparam logic [1:0] ARITH_ADD = 2'b01;
  localparam logic [1:0] ARITH_SUB = 2'b10;
  localparam logic [1:0] ARITH_DEC = 2'b11;
  localparam logic [1:0] LOG_AND   = 2'b00;
  localparam logic [1:0] LOG_OR    = 2'b01;
  localparam logic [1:0] LOG_XOR   = 2'b10;
  localparam logic [1:0] LOG_NOT   = 2'b11;
endpackage

// File: rtl/alu_arith_unit.sv
// alu_arith_unit: combinational Y-select plus carry-in adder, sum = A + Y + Cin
module alu_arith_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  logic [WIDTH-1:0] y;
  always_comb begin
    y = op == ARITH_TFR ? '0 : op == ARITH_ADD ? b : op == ARITH_SUB ? ~b : '1;
    {carry, sum} = {1'b0, a} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
  end
endmodule

// File: rtl/alu_32bit.sv
// alu_32bit: registered ALU with arithmetic, logic and 1-bit shift groups
module alu_32bit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             DinL,
  input  logic             DinR,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] F,
  output logic             Cout
);
  logic [WIDTH-1:0] sum, log_r, f_d, f_q;
  logic             carry, cout_d, cout_q;
  logic [1:0]       grp;
  alu_arith_unit #(.WIDTH(WIDTH)) u_arith (
    .a(A), .b(B), .cin(Cin), .op(sel[1:0]), .sum(sum), .carry(carry)
  );
  always_comb begin
    grp = sel[3:2];
    log_r = sel[1:0] == LOG_AND ? A & B : sel[1:0] == LOG_OR ? A | B :
            sel[1:0] == LOG_XOR ? A ^ B : ~A;
    f_d = grp == ALU_ARITH ? sum : grp == ALU_LOGIC ? log_r :
          grp == ALU_SHR ? {DinL, A[WIDTH-1:1]} : {A[WIDTH-2:0], DinR};
    cout_d = grp == ALU_ARITH && carry;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      f_q    <= f_d;
      cout_q <= cout_d;
    end
  end
  assign F    = f_q;
  assign Cout = cout_q;
endmodule

// File: tb/tb_alu_32bit.sv
// tb_alu_32bit: directed literal vectors plus randomized back-to-back traffic against a model
module tb_alu_32bit;
  logic        clk = 0, rst_n = 0, Cin = 0, DinL = 0, DinR = 0;
  logic [31:0] A = 0, B = 0;
  logic [3:0]  sel = 0;
  logic [31:0] F;
  logic        Cout;
  logic [31:0] exp_f;
  logic        exp_c;
  logic        exp_valid = 0;
  int          passed = 0, total = 0;

  alu_32bit dut (.clk(clk), .rst_n(rst_n), .A(A), .B(B), .Cin(Cin), .DinL(DinL),
                 .DinR(DinR), .sel(sel), .F(F), .Cout(Cout));

  always #5 clk = ~clk;

  function automatic logic [32:0] model(logic r, logic [3:0] s, logic [31:0] a, logic [31:0] b,
                                        logic c, logic dl, logic dr);
    logic [32:0] y, t;
    if (!r) return 33'd0;
    case (s[3:2])
      2'd0: begin
        y = s[1:0] == 0 ? 33'd0 : s[1:0] == 1 ? {1'b0, b} : s[1:0] == 2 ? {1'b0, ~b} : 33'hFFFFFFFF;
        t = {1'b0, a} + y + 33'(c);
        return t;
      end
      2'd1: case (s[1:0])
        0: return {1'b0, a & b};
        1: return {1'b0, a | b};
        2: return {1'b0, a ^ b};
        default: return {1'b0, ~a};
      endcase
      2'd2: return {1'b0, (a >> 1) | (32'(dl) << 31)};
      default: return {1'b0, (a << 1) | 32'(dr)};
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
  endtask

  always @(posedge clk) begin
    {exp_c, exp_f} <= model(rst_n, sel, A, B, Cin, DinL, DinR);
    exp_valid <= 1;
  end

  always @(negedge clk) if (exp_valid) begin
    check("model_F", F, exp_f);
    check("model_Cout", {31'b0, Cout}, {31'b0, exp_c});
  end

  task automatic apply(input string nm, input logic r, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] b, input logic c, input logic dl, input logic dr,
                       input logic [31:0] ef, input logic ec);
    @(negedge clk); #1;
    rst_n = r; sel = s; A = a; B = b; Cin = c; DinL = dl; DinR = dr;
    @(posedge clk); #1;
    check(nm, F, ef);
    check({nm, "_cout"}, {31'b0, Cout}, {31'b0, ec});
  endtask

  initial begin
    apply("rst", 0, 4'h5, 32'hFFFFFFFF, 0, 1, 1, 1, 32'h0, 0);
    apply("rst_rel", 1, 4'h5, 32'hFFFFFFFF, 0, 1, 1, 1, 32'hFFFFFFFF, 0);
    apply("inc_wrap", 1, 4'h0, 32'hFFFFFFFF, 0, 1, 0, 0, 32'h0, 1);
    apply("add_ff", 1, 4'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 32'hFFFFFFFE, 1);
    apply("add_mid", 1, 4'h1, 32'h80000000, 32'h7FFFFFFF, 0, 0, 0, 32'hFFFFFFFF, 0);
    apply("sub43_c0", 1, 4'h2, 4, 3, 0, 0, 0, 32'h0, 1);
    apply("sub43_c1", 1, 4'h2, 4, 3, 1, 0, 0, 32'h1, 1);
    apply("sub34_c0", 1, 4'h2, 3, 4, 0, 0, 0, 32'hFFFFFFFE, 0);
    apply("sub34_c1", 1, 4'h2, 3, 4, 1, 0, 0, 32'hFFFFFFFF, 0);
    apply("dec0", 1, 4'h3, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 0);
    apply("dec1", 1, 4'h3, 1, 0, 0, 0, 0, 32'h0, 1);
    apply("tfr_ff", 1, 4'h3, 32'hFFFFFFFF, 0, 1, 0, 0, 32'hFFFFFFFF, 1);
    apply("and", 1, 4'h4, 32'h0F0F0F0F, 32'hF0F0F0F0, 1, 0, 0, 32'h0, 0);
    apply("or", 1, 4'h5, 32'h0F0F0F0F, 32'hF0F0F0F0, 1, 0, 0, 32'hFFFFFFFF, 0);
    apply("xor", 1, 4'h6, 32'hAAAAAAAA, 32'h55555555, 1, 0, 0, 32'hFFFFFFFF, 0);
    apply("not", 1, 4'h7, 0, 32'h12345678, 1, 0, 0, 32'hFFFFFFFF, 0);
    apply("shr8_l1", 1, 4'h8, 32'h12345678, 32'hFFFFFFFF, 1, 1, 0, 32'h891A2B3C, 0);
    apply("shrA_l0", 1, 4'hA, 32'h12345678, 0, 1, 0, 1, 32'h091A2B3C, 0);
    apply("shlC_r1", 1, 4'hC, 32'h12345678, 32'hFFFFFFFF, 1, 0, 1, 32'h2468ACF1, 0);
    apply("shlD_r0", 1, 4'hD, 32'h12345678, 0, 1, 1, 0, 32'h2468ACF0, 0);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      rst_n = $urandom_range(31) != 0;
      sel = 4'($urandom);
      A = $urandom;
      B = $urandom;
      if ($urandom_range(7) == 0) A = 32'hFFFFFFFF;
      if ($urandom_range(7) == 0) B = A;
      Cin = 1'($urandom);
      DinL = 1'($urandom);
      DinR = 1'($urandom);
    end
    @(negedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
